// File: rtl/prbs_lock_checker.sv
// -----------------------------------------------------------------------------
// prbs_lock_checker
//
// PRBS checker for the SERDES receive path, placed after the deserializer and
// word aligner. It hunts for the sequence by seeding from received data, locks
// after a run of clean words, and from then on predicts each word purely from
// its own seed. A single line error is therefore counted once and never leaks
// into the prediction of the following word. Long-run counters are read by
// slow control.
//
// Pipeline for a valid word sampled at clock edge t:
//   edge t   : err_bits / err_valid / locked registered
//   edge t+1 : err_num (popcount of err_bits) registered
//   edge t+2 : accumulated counters updated
//
// Ports:
//   clk           word clock
//   rst           asynchronous, active-high reset
//   din           received word, din[0] is the earliest bit in time
//   din_valid     din qualifier; invalid cycles change no state
//   clr_cnt       synchronous clear of all four counters (beats increments)
//   locked        checker is in LOCKED
//   err_bits      expected ^ din for the compared word, else 0
//   err_valid     err_bits belongs to a compared word
//   err_num       popcount of err_bits, one cycle after err_bits
//   word_cnt      words compared while locked (saturating)
//   err_word_cnt  locked words with at least one bit error (saturating)
//   err_bit_cnt   errored bits seen while locked (saturating)
//   lock_loss_cnt LOCKED->HUNT transitions (saturating)
// -----------------------------------------------------------------------------
module prbs_lock_checker #(
  parameter int DATA_WIDTH   = 64,
  parameter int PRBS_ORDER   = 7,
  parameter int LOCK_COUNT   = 8,
  parameter int UNLOCK_COUNT = 4,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_WIDTH-1:0]             din,
  input  logic                              din_valid,
  input  logic                              clr_cnt,
  output logic                              locked,
  output logic [DATA_WIDTH-1:0]             err_bits,
  output logic                              err_valid,
  output logic [$clog2(DATA_WIDTH+1)-1:0]   err_num,
  output logic [CNT_WIDTH-1:0]              word_cnt,
  output logic [CNT_WIDTH-1:0]              err_word_cnt,
  output logic [CNT_WIDTH-1:0]              err_bit_cnt,
  output logic [7:0]                        lock_loss_cnt
);

  localparam int W     = DATA_WIDTH;
  localparam int N     = PRBS_ORDER;
  localparam int M     = (N == 7) ? 6 : (N == 15) ? 14 : (N == 23) ? 18 : 28;
  localparam int NUM_W = $clog2(W + 1);
  localparam int SUM_W = ((CNT_WIDTH > NUM_W) ? CNT_WIDTH : NUM_W) + 1;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Stage 1: lock FSM, seed and compare result
  state_e         state_q, state_d;
  logic [N-1:0]   seed_q, seed_d;
  logic           seed_ok_q, seed_ok_d;
  logic [7:0]     clean_run_q, clean_run_d;
  logic [7:0]     err_run_q, err_run_d;
  logic [W-1:0]   err_bits_q, err_bits_d;
  logic           err_valid_q, err_valid_d;
  logic           count_q, count_d;   // word compared while LOCKED
  logic           loss_q, loss_d;     // this word dropped lock

  // Stage 2: popcount
  logic [NUM_W-1:0] err_num_q;
  logic             count2_q;
  logic             loss2_q;

  // Stage 3: accumulated counters
  logic [CNT_WIDTH-1:0] word_cnt_q, err_word_cnt_q, err_bit_cnt_q;
  logic [7:0]           lock_loss_cnt_q;

  // ---------------------------------------------------------------------------
  // Expected word: unroll s[n] = s[n-N] ^ s[n-M] across the word, starting from
  // the seed (seed[0] oldest). ext[N+j] is the expected bit j of this word.
  // ---------------------------------------------------------------------------
  logic [N+W-1:0] ext;
  logic [W-1:0]   expected;
  logic [W-1:0]   diff;
  logic           compared;
  logic           word_bad;

  always_comb begin
    ext          = '0;
    ext[N-1:0]   = seed_q;
    for (int j = 0; j < W; j++) begin
      ext[N+j] = ext[j] ^ ext[j+N-M];
    end
    expected = ext[N+W-1:N];
  end

  assign diff     = expected ^ din;
  assign word_bad = |diff;
  // In HUNT a word needs a real predecessor; an all-zero seed would predict an
  // all-zero word and let the checker lock onto a dead link.
  assign compared = (state_q == LOCKED) || (seed_ok_q && (seed_q != '0));

  // NOTE: every _d is given its hold value before any branch, so no path
  // through this block can leave a variable unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    seed_d      = seed_q;
    seed_ok_d   = seed_ok_q;
    clean_run_d = clean_run_q;
    err_run_d   = err_run_q;
    err_bits_d  = '0;
    err_valid_d = 1'b0;
    count_d     = 1'b0;
    loss_d      = 1'b0;

    if (din_valid) begin
      seed_ok_d   = 1'b1;
      err_valid_d = compared;
      err_bits_d  = compared ? diff : '0;

      case (state_q)
        HUNT: begin
          seed_d    = din[W-1 -: N];
          err_run_d = '0;
          if (!compared || word_bad) begin
            clean_run_d = '0;
          end else if (clean_run_q == 8'(LOCK_COUNT - 1)) begin
            state_d     = LOCKED;
            clean_run_d = '0;
          end else begin
            clean_run_d = clean_run_q + 8'd1;
          end
        end

        LOCKED: begin
          // Self-prediction: din never reaches the seed while locked.
          seed_d      = expected[W-1 -: N];
          count_d     = 1'b1;
          clean_run_d = '0;
          if (!word_bad) begin
            err_run_d = '0;
          end else if (err_run_q == 8'(UNLOCK_COUNT - 1)) begin
            state_d   = HUNT;
            seed_ok_d = 1'b0;
            err_run_d = '0;
            loss_d    = 1'b1;
          end else begin
            err_run_d = err_run_q + 8'd1;
          end
        end

        default: state_d = HUNT;
      endcase
    end
  end

  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HUNT;
      seed_q      <= '0;
      seed_ok_q   <= 1'b0;
      clean_run_q <= '0;
      err_run_q   <= '0;
      err_bits_q  <= '0;
      err_valid_q <= 1'b0;
      count_q     <= 1'b0;
      loss_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      seed_q      <= seed_d;
      seed_ok_q   <= seed_ok_d;
      clean_run_q <= clean_run_d;
      err_run_q   <= err_run_d;
      err_bits_q  <= err_bits_d;
      err_valid_q <= err_valid_d;
      count_q     <= count_d;
      loss_q      <= loss_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: registered popcount of the compared word's error bits.
  // ---------------------------------------------------------------------------
  function automatic logic [NUM_W-1:0] popcount(input logic [W-1:0] v);
    logic [NUM_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < W; i++) begin
      sum = sum + NUM_W'(v[i]);
    end
    return sum;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_num_q <= '0;
      count2_q  <= 1'b0;
      loss2_q   <= 1'b0;
    end else begin
      err_num_q <= popcount(err_bits_q);
      count2_q  <= count_q;
      loss2_q   <= loss_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: saturating counters. The sum is formed one bit wider than either
  // operand so an overflow is seen before it wraps.
  // ---------------------------------------------------------------------------
  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [NUM_W-1:0]     b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (s > SUM_W'({CNT_WIDTH{1'b1}})) begin
      return '1;
    end
    return s[CNT_WIDTH-1:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt_q      <= '0;
      err_word_cnt_q  <= '0;
      err_bit_cnt_q   <= '0;
      lock_loss_cnt_q <= '0;
    end else if (clr_cnt) begin
      word_cnt_q      <= '0;
      err_word_cnt_q  <= '0;
      err_bit_cnt_q   <= '0;
      lock_loss_cnt_q <= '0;
    end else begin
      if (count2_q) begin
        word_cnt_q    <= sat_add(word_cnt_q, NUM_W'(1));
        err_bit_cnt_q <= sat_add(err_bit_cnt_q, err_num_q);
        if (err_num_q != '0) begin
          err_word_cnt_q <= sat_add(err_word_cnt_q, NUM_W'(1));
        end
      end
      if (loss2_q && (lock_loss_cnt_q != 8'hFF)) begin
        lock_loss_cnt_q <= lock_loss_cnt_q + 8'd1;
      end
    end
  end

  assign locked        = (state_q == LOCKED);
  assign err_bits      = err_bits_q;
  assign err_valid     = err_valid_q;
  assign err_num       = err_num_q;
  assign word_cnt      = word_cnt_q;
  assign err_word_cnt  = err_word_cnt_q;
  assign err_bit_cnt   = err_bit_cnt_q;
  assign lock_loss_cnt = lock_loss_cnt_q;

endmodule
